// File: rtl/ara_pkg.sv
// Shared width rules for the VRF SRAM initiator and its response FIFO.
// Latency: n/a (elaboration-time constants and functions only).
// Backpressure: n/a.
package ara_pkg;

  // Word-address width; a single-word memory still gets a 1-bit address.
  function automatic int unsigned addr_width(input int unsigned num_words);
    return (num_words > 1) ? $clog2(num_words) : 1;
  endfunction

  // One enable per ByteWidth-bit lane, a partial top lane included.
  function automatic int unsigned be_width(input int unsigned data_width,
                                           input int unsigned byte_width);
    return (data_width + byte_width - 1) / byte_width;
  endfunction

  // Counter able to hold 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/vrf_rsp_fifo.sv
// Response FIFO: buffers SRAM read data until the consumer pops it.
// Latency: a push is visible on valid_o/rdata_o the cycle after it is written.
// Backpressure: none upstream; the caller guarantees no push when full without a pop.
// Ports: clk_i/rst_i (sync active-high), push_i/wdata_i write side,
//        pop_i read side (ignored when empty), valid_o/rdata_o head entry.
module vrf_rsp_fifo
  import ara_pkg::*;
#(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 128
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [Width-1:0] rdata_o
);

  localparam int unsigned PtrWidth = addr_width(Depth);
  localparam int unsigned CntWidth = cnt_width(Depth);
  localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(Depth - 1);

  logic [Width-1:0]    mem_q [Depth];
  logic [Width-1:0]    mem_d [Depth];
  logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntWidth-1:0] count_q, count_d;
  logic                do_pop;

  assign valid_o = (count_q != '0);
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_pop  = pop_i && valid_o;

  // When full, push and pop hit the same slot: the head is read this cycle
  // and overwritten at the edge, so both take effect.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) begin
      mem_d[wr_ptr_q] = wdata_i;
      wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrWidth'(1);
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrWidth'(1);
    end
    case ({push_i, do_pop})
      2'b10:   count_d = count_q + CntWidth'(1);
      2'b01:   count_d = count_q - CntWidth'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/vrf_sram_initiator.sv
// Credit-based initiator driving a single-port SRAM and returning read data in order.
// Latency: read accepted in cycle t is sampled at end of t+Latency, rsp_valid_o from t+Latency+1.
// Backpressure: reads stall when RspDepth are outstanding unless a response pops this cycle; writes never stall.
// Ports: clk_i/rst_i (sync active-high); req_* request channel (valid/ready);
//        rsp_* read response channel (valid/ready); sram_* single-port memory interface.
module vrf_sram_initiator
  import ara_pkg::*;
#(
  parameter int unsigned NumWords  = 1024,
  parameter int unsigned DataWidth = 128,
  parameter int unsigned ByteWidth = 8,
  parameter int unsigned Latency   = 1,  // legal 1..4
  parameter int unsigned RspDepth  = 2,  // must be >= Latency
  localparam int unsigned AddrWidth = addr_width(NumWords),
  localparam int unsigned BeWidth   = be_width(DataWidth, ByteWidth)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [DataWidth-1:0] req_wdata_i,
  input  logic [BeWidth-1:0]   req_be_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DataWidth-1:0] rsp_rdata_o,
  output logic                 sram_req_o,
  output logic                 sram_we_o,
  output logic [AddrWidth-1:0] sram_addr_o,
  output logic [DataWidth-1:0] sram_wdata_o,
  output logic [BeWidth-1:0]   sram_be_o,
  input  logic [DataWidth-1:0] sram_rdata_i
);

  localparam int unsigned CntWidth = cnt_width(RspDepth);
  localparam logic [CntWidth-1:0] MaxOutstanding = CntWidth'(RspDepth);

  // outstanding = reads in the SRAM pipeline + entries waiting in the FIFO.
  logic [CntWidth-1:0] outstanding_q, outstanding_d;
  logic [Latency-1:0]  tag_q, tag_d;
  logic                fifo_vld;
  logic                rsp_hs;
  logic                read_acc;

  // Outputs are forced low during reset so nothing leaks while state clears.
  assign rsp_valid_o = fifo_vld && !rst_i;
  assign rsp_hs      = rsp_valid_o && rsp_ready_i;

  // A pop in the same cycle frees a credit, so rsp_ready_i reaches
  // req_ready_o combinationally; this keeps a full FIFO streaming.
  assign req_ready_o = !rst_i &&
                       (req_we_i || (outstanding_q < MaxOutstanding) || rsp_hs);
  assign read_acc    = req_valid_i && req_ready_o && !req_we_i;

  // Memory ordering (write-then-read) is left to the SRAM itself.
  assign sram_req_o   = req_valid_i && req_ready_o;
  assign sram_we_o    = req_we_i;
  assign sram_addr_o  = req_addr_i;
  assign sram_wdata_o = req_wdata_i;
  assign sram_be_o    = req_be_i;

  // Tag pipeline mirrors the SRAM read latency; its tail marks the cycle
  // in which sram_rdata_i carries data for an accepted read.
  always_comb begin
    tag_d    = tag_q;
    tag_d[0] = read_acc;
    for (int unsigned i = 1; i < Latency; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  always_comb begin
    case ({read_acc, rsp_hs})
      2'b10:   outstanding_d = outstanding_q + CntWidth'(1);
      2'b01:   outstanding_d = outstanding_q - CntWidth'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  // Clearing the tags drops any read still inside the SRAM pipeline.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      outstanding_q <= '0;
      tag_q         <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      tag_q         <= tag_d;
    end
  end

  vrf_rsp_fifo #(
    .Depth (RspDepth),
    .Width (DataWidth)
  ) i_rsp_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (tag_q[Latency-1]),
    .wdata_i (sram_rdata_i),
    .pop_i   (rsp_hs),
    .valid_o (fifo_vld),
    .rdata_o (rsp_rdata_o)
  );

endmodule
